// File: rtl/csa3_serial_adder.sv
// Nibble-serial adder of three WIDTH-bit operands plus carry-in.
// One 4-bit slice is reduced per RUN cycle; the 2-bit carry ripples between slices.
module csa3_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH+1:0] sum,
    output logic             busy
);
    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int SW    = WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [1:0]         carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, c_q, c_d;
    logic [SW-1:0]      sum_q, sum_d;
    logic [IDX_W+1:0]   sh_s;
    logic [5:0]         slice_s;
    logic               last_s;

    // 3:2 compression of the three nibbles, then one add folds in the carry pair.
    function automatic logic [5:0] slice3(input logic [3:0] a, input logic [3:0] b,
                                          input logic [3:0] c, input logic [1:0] cy);
        logic [3:0] s;
        logic [3:0] m;
        s = a ^ b ^ c;
        m = (a & b) | (a & c) | (b & c);
        return 6'(s) + {1'b0, m, 1'b0} + 6'(cy);
    endfunction

    // Current-slice arithmetic.
    always_comb begin
        sh_s    = {idx_q, 2'b00};
        slice_s = slice3(4'(a_q >> sh_s), 4'(b_q >> sh_s), 4'(c_q >> sh_s), carry_q);
        last_s  = (idx_q == IDX_W'(NIB - 1));
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        sum_d   = sum_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in1;
                    b_d     = in2;
                    c_d     = in3;
                    carry_d = {1'b0, cin};
                    idx_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sum_d   = (sum_q & ~(SW'(4'hF) << sh_s)) | (SW'(slice_s[3:0]) << sh_s);
                carry_d = slice_s[5:4];
                if (last_s) begin
                    sum_d[SW-1:WIDTH] = slice_s[5:4];
                    state_d           = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 2'b00;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            sum_q   <= sum_d;
        end
    end

    // Handshake outputs decode straight from the state register.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        sum       = sum_q;
    end
endmodule

// File: tb/tb_csa3_serial_adder.sv
// Randomised scoreboard bench for csa3_serial_adder (WIDTH=16) plus a WIDTH=4 instance.
module tb_csa3_serial_adder;
    localparam int W   = 16;
    localparam int NIB = W / 4;

    typedef struct {
        logic [W+1:0] sum;
        int           acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, in_ready, cin, out_valid, out_ready, busy;
    logic [W-1:0] in1, in2, in3;
    logic [W+1:0] sum;

    logic iv4, ir4, ci4, ov4, or4, busy4;
    logic [3:0] a4, b4, c4;
    logic [5:0] sum4;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    logic prev_ov = 1'b0;
    logic rand_ready = 1'b0;

    always #5 clk = ~clk;

    csa3_serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .in3(in3), .cin(cin), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .busy(busy)
    );

    csa3_serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4),
        .in1(a4), .in2(b4), .in3(c4), .cin(ci4), .out_valid(ov4),
        .out_ready(or4), .sum(sum4), .busy(busy4)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Random consumer backpressure, changed well after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: latency on each out_valid rise, result on each handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_ov <= 1'b0;
        end else begin
            if (out_valid && !prev_ov) begin
                if (sb_q.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
                else chk("latency", cyc - sb_q[0].acc, NIB);
            end
            if (out_valid && out_ready && sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("sum", sum, e.sum);
            end
            prev_ov <= out_valid;
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] c, input logic ci);
        int n = 0;
        int unsigned t;
        exp_t e;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("send_timeout", 32'd1, 32'd0);
        end else begin
            in1 = a; in2 = b; in3 = c; cin = ci; in_valid = 1'b1;
            t = a + b + c + ci;
            e.sum = t[W+1:0];
            e.acc = cyc + 1;
            sb_q.push_back(e);
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb_q.size() != 0 || !in_ready) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0 || !in_ready) chk("drain_timeout", sb_q.size(), 0);
    endtask

    initial begin
        int n;
        logic [W+1:0] held;
        rst = 1'b1; in_valid = 1'b0; in1 = '0; in2 = '0; in3 = '0; cin = 1'b0;
        out_ready = 1'b0;
        iv4 = 1'b0; a4 = 4'h0; b4 = 4'h0; c4 = 4'h0; ci4 = 1'b0; or4 = 1'b0;
        #3;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sum", sum, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // WIDTH=4: single RUN cycle
        @(negedge clk);
        iv4 = 1'b1; a4 = 4'hF; b4 = 4'hF; c4 = 4'hF; ci4 = 1'b1;
        @(posedge clk);
        #1 iv4 = 1'b0;
        chk("w4_busy", busy4, 1);
        chk("w4_ov_early", ov4, 0);
        @(posedge clk);
        #1;
        chk("w4_out_valid", ov4, 1);
        chk("w4_sum", sum4, 15 * 3 + 1);
        or4 = 1'b1;
        @(posedge clk);
        #1 chk("w4_idle", ir4, 1);

        // directed corners under random backpressure
        rand_ready = 1'b1;
        send(16'h0000, 16'h0000, 16'h0000, 1'b0);
        send(16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1);
        send(16'h1234, 16'h5678, 16'h9ABC, 1'b0);
        wait_idle();

        // held result under backpressure, in_valid ignored
        rand_ready = 1'b0;
        out_ready = 1'b0;
        send(16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_reach_done", out_valid, 1);
        held = (sb_q.size() != 0) ? sb_q[0].sum : '0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1; in1 = 16'($urandom); in2 = 16'($urandom);
            in3 = 16'($urandom); cin = ~cin;
            @(negedge clk);
            chk("bp_sum_stable", sum, held);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_idle", in_ready, 1);
        chk("bp_release_ov", out_valid, 0);
        chk("retain_sum", sum, held);
        wait_idle();

        // reset during slice 2 discards the transaction
        send(16'hA5A5, 16'h5A5A, 16'hFFFF, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_sum", sum, 0);
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (out_valid) chk("ghost_valid", out_valid, 0);
        end
        send(16'h0001, 16'h0001, 16'h0001, 1'b1);
        wait_idle();

        // randomised traffic
        rand_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (k % 10 == 0) send(16'hFFFF, 16'hFFFF, 16'($urandom), 1'b1);
            else send(16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        end
        wait_idle();
        chk("sb_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
